// File: rtl/apb_timer_mc_if.sv
// APB slave bundle for apb_timer_mc: select/enable/address/data in, ready/error/read data out.
interface apb_timer_mc_if;
  localparam int unsigned AddrW = 12;
  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = DataW / 8;

  logic             tim_psel;
  logic             tim_penable;
  logic             tim_pwrite;
  logic [AddrW-1:0] tim_paddr;
  logic [DataW-1:0] tim_pwdata;
  logic [StrbW-1:0] tim_pstrb;
  logic             tim_pready;
  logic             tim_pslverr;
  logic [DataW-1:0] tim_prdata;

  modport master (
    output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    input  tim_pready, tim_pslverr, tim_prdata
  );

  modport slave (
    input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    output tim_pready, tim_pslverr, tim_prdata
  );
endinterface

// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer: per-channel prescaler, up-counter, compare/auto-reload and maskable interrupt.
// Optional feature macro TIMER_ONESHOT_EN adds CTRL[3] oneshot (auto-disable on match).
module apb_timer_mc #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  apb_timer_mc_if.slave   apb,
  input  logic            dbg_mode,
  output logic            tim_int,
  output logic [N_CH-1:0] tim_int_ch
);

  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = DataW / 8;
  localparam int unsigned DivW  = 4;
  localparam int unsigned BlkW  = 8;
  localparam logic [9:0]  HaltWord = 10'h040;

`ifdef TIMER_ONESHOT_EN
  localparam bit OneShotEn = 1'b1;
`else
  localparam bit OneShotEn = 1'b0;
`endif

  function automatic logic [DataW-1:0] merge_bytes(input logic [DataW-1:0] old_v,
                                                   input logic [DataW-1:0] new_v,
                                                   input logic [StrbW-1:0] strb);
    logic [DataW-1:0] r;
    r = old_v;
    for (int unsigned i = 0; i < StrbW; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [DataW-1:0] ctrl_word(input logic en, input logic ar, input logic de,
                                                 input logic os, input logic [DivW-1:0] dv);
    return {20'd0, dv, 4'd0, os, de, ar, en};
  endfunction

  // channel and global state
  logic [N_CH-1:0]  en_q, en_d, ar_q, ar_d, de_q, de_d, os_q, os_d;
  logic [N_CH-1:0]  ist_q, ist_d, ien_q, ien_d;
  logic [DivW-1:0]  dv_q  [N_CH];
  logic [DivW-1:0]  dv_d  [N_CH];
  logic [DivW-1:0]  psc_q [N_CH];
  logic [DivW-1:0]  psc_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] cmp_q [N_CH];
  logic [CNT_W-1:0] cmp_d [N_CH];
  logic             halt_req_q, halt_req_d, halt_ack_q, halt_ack_d;

  logic             access_c, ch_hit_c, halt_hit_c, mapped_c, wr_c;
  logic [BlkW-1:0]  blk_c;
  logic [1:0]       off_c;
  logic [N_CH-1:0]  sel_c;
  logic [DataW-1:0] rdata_c;

  // Address decode; reset gates the access so no response is given while in reset
  always_comb begin
    access_c   = apb.tim_psel & apb.tim_penable & sys_rst_n;
    blk_c      = apb.tim_paddr[11:4];
    off_c      = apb.tim_paddr[3:2];
    ch_hit_c   = (32'(blk_c) < N_CH) && (apb.tim_paddr[1:0] == 2'd0);
    halt_hit_c = (apb.tim_paddr[11:2] == HaltWord) && (apb.tim_paddr[1:0] == 2'd0);
    mapped_c   = ch_hit_c | halt_hit_c;
    wr_c       = access_c & apb.tim_pwrite & mapped_c;
    sel_c      = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      sel_c[c] = ch_hit_c && (blk_c == BlkW'(c));
    end
  end

  always_comb begin
    logic             tick;
    logic             hit;
    logic [CNT_W-1:0] nxt;
    logic [DataW-1:0] m;
    en_d  = en_q;
    ar_d  = ar_q;
    de_d  = de_q;
    os_d  = os_q;
    ist_d = ist_q;
    ien_d = ien_q;
    halt_req_d = halt_req_q;
    halt_ack_d = halt_req_q & dbg_mode;
    tick = 1'b0;
    hit  = 1'b0;
    nxt  = '0;
    m    = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      dv_d[c]  = dv_q[c];
      psc_d[c] = psc_q[c];
      cnt_d[c] = cnt_q[c];
      cmp_d[c] = cmp_q[c];
      tick = en_q[c] & ~halt_ack_q & (~de_q[c] | (psc_q[c] == dv_q[c]));
      hit  = 1'b0;
      nxt  = (ar_q[c] && (cnt_q[c] == cmp_q[c])) ? '0 : cnt_q[c] + CNT_W'(1);
      m    = '0;

      if (!en_q[c]) begin
        psc_d[c] = '0;
      end else if (!halt_ack_q) begin
        psc_d[c] = (de_q[c] && (psc_q[c] != dv_q[c])) ? psc_q[c] + DivW'(1) : '0;
      end

      if (tick) begin
        cnt_d[c] = nxt;
        hit      = (nxt == cmp_q[c]);
      end

      // Software writes; a CNT write overrides (and discards) a same-cycle tick
      if (wr_c && sel_c[c]) begin
        case (off_c)
          2'd0: begin
            m = merge_bytes(ctrl_word(en_q[c], ar_q[c], de_q[c], os_q[c], dv_q[c]),
                            apb.tim_pwdata, apb.tim_pstrb);
            en_d[c] = m[0];
            ar_d[c] = m[1];
            de_d[c] = m[2];
            os_d[c] = m[3] & OneShotEn;
            dv_d[c] = m[11:8];
            if (apb.tim_pstrb[0] || apb.tim_pstrb[1]) psc_d[c] = '0;
          end
          2'd1: begin
            cnt_d[c] = CNT_W'(merge_bytes(DataW'(cnt_q[c]), apb.tim_pwdata, apb.tim_pstrb));
            hit      = 1'b0;
          end
          2'd2: cmp_d[c] = CNT_W'(merge_bytes(DataW'(cmp_q[c]), apb.tim_pwdata, apb.tim_pstrb));
          default: begin
            if (apb.tim_pstrb[0]) begin
              ien_d[c] = apb.tim_pwdata[1];
              if (apb.tim_pwdata[0]) ist_d[c] = 1'b0;
            end
          end
        endcase
      end

      // Hardware set beats W1C; oneshot drops en on the matching edge
      if (hit) begin
        ist_d[c] = 1'b1;
        if (os_q[c]) en_d[c] = 1'b0;
      end
    end

    if (wr_c && halt_hit_c && apb.tim_pstrb[0]) halt_req_d = apb.tim_pwdata[0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_q  <= '0;
      ar_q  <= '0;
      de_q  <= '0;
      os_q  <= '0;
      ist_q <= '0;
      ien_q <= '0;
      halt_req_q <= 1'b0;
      halt_ack_q <= 1'b0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        dv_q[c]  <= '0;
        psc_q[c] <= '0;
        cnt_q[c] <= '0;
        cmp_q[c] <= '1;
      end
    end else begin
      en_q  <= en_d;
      ar_q  <= ar_d;
      de_q  <= de_d;
      os_q  <= os_d;
      ist_q <= ist_d;
      ien_q <= ien_d;
      halt_req_q <= halt_req_d;
      halt_ack_q <= halt_ack_d;
      for (int unsigned c = 0; c < N_CH; c++) begin
        dv_q[c]  <= dv_d[c];
        psc_q[c] <= psc_d[c];
        cnt_q[c] <= cnt_d[c];
        cmp_q[c] <= cmp_d[c];
      end
    end
  end

  // Read mux: data only during a read access phase to a mapped register
  always_comb begin
    rdata_c = '0;
    if (access_c && !apb.tim_pwrite) begin
      if (halt_hit_c) rdata_c = {30'd0, halt_ack_q, halt_req_q};
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (sel_c[c]) begin
          case (off_c)
            2'd0:    rdata_c = ctrl_word(en_q[c], ar_q[c], de_q[c], os_q[c], dv_q[c]);
            2'd1:    rdata_c = DataW'(cnt_q[c]);
            2'd2:    rdata_c = DataW'(cmp_q[c]);
            default: rdata_c = {30'd0, ien_q[c], ist_q[c]};
          endcase
        end
      end
    end
  end

  assign apb.tim_pready  = access_c;
  assign apb.tim_pslverr = access_c & ~mapped_c;
  assign apb.tim_prdata  = rdata_c;
  assign tim_int_ch      = ist_q & ien_q;
  assign tim_int         = |tim_int_ch;

endmodule

// File: tb/tb_apb_timer_mc.sv
// Self-checking bench for apb_timer_mc: directed scenarios plus randomized channel setups
// checked against closed-form tick arithmetic.
module tb_apb_timer_mc;
  logic       clk;
  logic       rst_n;
  logic       dbg;
  logic       tim_int;
  logic [3:0] tim_int_ch;
  int         checks;
  int         errors;
  int unsigned cyc;
  logic       werr;

  apb_timer_mc_if bus();

  apb_timer_mc #(.N_CH(4), .CNT_W(32)) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .apb        (bus),
    .dbg_mode   (dbg),
    .tim_int    (tim_int),
    .tim_int_ch (tim_int_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic e);
    @(posedge clk); #1;
    bus.tim_psel = 1'b1; bus.tim_penable = 1'b0; bus.tim_pwrite = 1'b1;
    bus.tim_paddr = a; bus.tim_pwdata = d; bus.tim_pstrb = s;
    @(posedge clk); #1;
    bus.tim_penable = 1'b1;
    #1 e = bus.tim_pslverr;
    @(posedge clk); #1;
    bus.tim_psel = 1'b0; bus.tim_penable = 1'b0; bus.tim_pwrite = 1'b0;
  endtask

  // Returns read data, error flag and the cycle index at which it was sampled
  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e,
                        output int unsigned t);
    @(posedge clk); #1;
    bus.tim_psel = 1'b1; bus.tim_penable = 1'b0; bus.tim_pwrite = 1'b0;
    bus.tim_paddr = a; bus.tim_pstrb = 4'h0;
    @(posedge clk); #1;
    bus.tim_penable = 1'b1;
    #1 begin d = bus.tim_prdata; e = bus.tim_pslverr; t = cyc; end
    @(posedge clk); #1;
    bus.tim_psel = 1'b0; bus.tim_penable = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d, exp;
    logic e;
    int unsigned t;
    rst_n = 1'b0; dbg = 1'b0;
    bus.tim_psel = 1'b0; bus.tim_penable = 1'b0; bus.tim_pwrite = 1'b0;
    bus.tim_paddr = '0; bus.tim_pwdata = '0; bus.tim_pstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.tim_pready, bus.tim_pslverr, tim_int, tim_int_ch} !== 7'd0 || bus.tim_prdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b err=%b int=%b ch=%b rd=%h want all 0",
               bus.tim_pready, bus.tim_pslverr, tim_int, tim_int_ch, bus.tim_prdata);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        apb_rd(12'(c * 16 + r * 4), d, e, t);
        exp = (r == 2) ? 32'hFFFF_FFFF : 32'd0;
        checks++;
        if (d !== exp || e !== 1'b0) begin
          errors++;
          $display("FAIL reset_reg ch%0d off%0d got %h err=%b want %h", c, r * 4, d, e, exp);
        end
      end
    end
    apb_rd(12'h100, d, e, t);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL reset_halt got %h want 0", d);
    end
  endtask

  task automatic test_reload;
    logic [31:0] d;
    logic e;
    int unsigned t, t_en, big_t;
    apb_wr(12'h018, 32'd5, 4'hF, werr);
    apb_wr(12'h01C, 32'd2, 4'hF, werr);
    apb_wr(12'h010, 32'd3, 4'hF, werr);
    t_en = cyc;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      apb_rd(12'h014, d, e, t);
      checks++;
      if (d !== 32'((t - t_en) % 6)) begin
        errors++;
        $display("FAIL reload_cnt got %0d want %0d", d, (t - t_en) % 6);
      end
    end
    // Re-arm from 0 and watch the interrupt line edge by edge
    apb_wr(12'h010, 32'd0, 4'hF, werr);
    apb_wr(12'h014, 32'd0, 4'hF, werr);
    apb_wr(12'h01C, 32'd3, 4'hF, werr);
    apb_wr(12'h010, 32'd3, 4'hF, werr);
    t_en = cyc;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      big_t = cyc - t_en;
      checks++;
      if (tim_int_ch[1] !== (big_t >= 5) || tim_int !== (big_t >= 5)) begin
        errors++;
        $display("FAIL reload_int T=%0d got ch1=%b int=%b want %b", big_t, tim_int_ch[1], tim_int, big_t >= 5);
      end
    end
    apb_wr(12'h010, 32'd0, 4'hF, werr);
    big_t = cyc - t_en;
    repeat (3) @(posedge clk);
    apb_rd(12'h014, d, e, t);
    checks++;
    if (d !== 32'(big_t % 6)) begin
      errors++;
      $display("FAIL reload_hold got %0d want %0d", d, big_t % 6);
    end
    apb_wr(12'h01C, 32'd3, 4'hF, werr);
    #1;
    checks++;
    if (tim_int_ch[1] !== 1'b0 || tim_int !== 1'b0) begin
      errors++;
      $display("FAIL reload_w1c got ch1=%b int=%b want 0", tim_int_ch[1], tim_int);
    end
  endtask

  task automatic test_prescaler;
    logic [31:0] d;
    logic e;
    int unsigned t, t_en, big_t;
    apb_wr(12'h008, 32'd2, 4'hF, werr);
    apb_wr(12'h00C, 32'd2, 4'hF, werr);
    apb_wr(12'h000, 32'h305, 4'hF, werr);
    t_en = cyc;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      big_t = cyc - t_en;
      checks++;
      if (tim_int_ch[0] !== ((big_t / 4) >= 2)) begin
        errors++;
        $display("FAIL presc_int T=%0d got %b want %b", big_t, tim_int_ch[0], (big_t / 4) >= 2);
      end
    end
    apb_rd(12'h004, d, e, t);
    checks++;
    if (d !== 32'((t - t_en) / 4)) begin
      errors++;
      $display("FAIL presc_cnt got %0d want %0d", d, (t - t_en) / 4);
    end
    apb_wr(12'h000, 32'd0, 4'hF, werr);
    apb_wr(12'h00C, 32'd1, 4'hF, werr);
  endtask

  task automatic test_strobe;
    logic [31:0] d;
    logic e;
    int unsigned t;
    apb_wr(12'h028, 32'hAABB_CCDD, 4'b0010, werr);
    apb_rd(12'h028, d, e, t);
    checks++;
    if (d !== 32'hFFFF_CCFF) begin
      errors++;
      $display("FAIL strobe_a got %h want FFFFCCFF", d);
    end
    apb_wr(12'h028, 32'h1122_3344, 4'b1001, werr);
    apb_rd(12'h028, d, e, t);
    checks++;
    if (d !== 32'h11FF_CC44) begin
      errors++;
      $display("FAIL strobe_b got %h want 11FFCC44", d);
    end
  endtask

  task automatic test_halt;
    logic [31:0] d;
    logic e;
    int unsigned t, t_en, t_h, t_d, frozen;
    dbg = 1'b1;
    apb_wr(12'h030, 32'd1, 4'hF, werr);
    t_en = cyc;
    repeat (3) @(posedge clk);
    apb_wr(12'h100, 32'd1, 4'hF, werr);
    t_h = cyc;
    frozen = t_h + 1 - t_en;
    apb_rd(12'h100, d, e, t);
    checks++;
    if (d !== 32'd3) begin
      errors++;
      $display("FAIL halt_ack got %h want 3", d);
    end
    for (int k = 0; k < 2; k++) begin
      apb_rd(12'h034, d, e, t);
      checks++;
      if (d !== frozen) begin
        errors++;
        $display("FAIL halt_frozen got %0d want %0d", d, frozen);
      end
    end
    @(posedge clk); #1;
    dbg = 1'b0;
    t_d = cyc;
    repeat (2) @(posedge clk);
    apb_rd(12'h034, d, e, t);
    checks++;
    if (d !== frozen + (t - (t_d + 1))) begin
      errors++;
      $display("FAIL halt_resume got %0d want %0d", d, frozen + (t - (t_d + 1)));
    end
    apb_rd(12'h100, d, e, t);
    checks++;
    if (d !== 32'd1) begin
      errors++;
      $display("FAIL halt_release got %h want 1", d);
    end
    apb_wr(12'h100, 32'd0, 4'hF, werr);
    apb_wr(12'h030, 32'd0, 4'hF, werr);
  endtask

  task automatic test_unmapped;
    logic [31:0] d;
    logic e;
    int unsigned t;
    logic [11:0] addrs [2];
    addrs[0] = 12'h040;
    addrs[1] = 12'h200;
    for (int i = 0; i < 2; i++) begin
      apb_wr(addrs[i], 32'hFFFF_FFFF, 4'hF, werr);
      checks++;
      if (werr !== 1'b1) begin
        errors++;
        $display("FAIL unmapped_wr_err addr %h got %b want 1", addrs[i], werr);
      end
      apb_rd(addrs[i], d, e, t);
      checks++;
      if (e !== 1'b1 || d !== 32'd0) begin
        errors++;
        $display("FAIL unmapped_rd addr %h got err=%b data=%h want err=1 data=0", addrs[i], e, d);
      end
    end
    apb_rd(12'h008, d, e, t);
    checks++;
    if (d !== 32'd2 || e !== 1'b0) begin
      errors++;
      $display("FAIL unmapped_nochange got %h err=%b want 2 err=0", d, e);
    end
    apb_rd(12'h000, d, e, t);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL unmapped_ctrl0 got %h want 0", d);
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] d;
    logic e;
    int unsigned t;
`ifdef TIMER_ONESHOT_EN
    apb_wr(12'h028, 32'd3, 4'hF, werr);
    apb_wr(12'h024, 32'd0, 4'hF, werr);
    apb_wr(12'h020, 32'h9, 4'hF, werr);
    repeat (8) @(posedge clk);
    apb_rd(12'h024, d, e, t);
    checks++;
    if (d !== 32'd3) begin
      errors++;
      $display("FAIL oneshot_cnt got %0d want 3", d);
    end
    apb_rd(12'h020, d, e, t);
    checks++;
    if (d !== 32'h8) begin
      errors++;
      $display("FAIL oneshot_ctrl got %h want 8", d);
    end
    apb_rd(12'h02C, d, e, t);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL oneshot_int got %h want 1", d);
    end
`else
    apb_wr(12'h020, 32'h8, 4'hF, werr);
    apb_rd(12'h020, d, e, t);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL oneshot_absent got %h want 0", d);
    end
`endif
    apb_wr(12'h020, 32'h0, 4'hF, werr);
    apb_wr(12'h02C, 32'h1, 4'hF, werr);
  endtask

  // Randomized channel setup; expected count is ticks = floor(T/period), folded by cmp+1 on reload
  task automatic test_random;
    logic [31:0] d;
    logic e;
    int unsigned t, t_en, c, cmp, dv, per, ticks, exp_cnt;
    logic de, ar, ie;
    for (int it = 0; it < 12; it++) begin
      c   = $urandom_range(0, 3);
      cmp = $urandom_range(1, 12);
      dv  = $urandom_range(0, 3);
      de  = 1'($urandom_range(0, 1));
      ar  = 1'($urandom_range(0, 1));
      ie  = 1'($urandom_range(0, 1));
      per = de ? dv + 1 : 1;
      apb_wr(12'(c * 16), 32'd0, 4'hF, werr);
      apb_wr(12'(c * 16 + 4), 32'd0, 4'hF, werr);
      apb_wr(12'(c * 16 + 12), {30'd0, ie, 1'b1}, 4'hF, werr);
      apb_wr(12'(c * 16 + 8), cmp, 4'hF, werr);
      apb_wr(12'(c * 16), {20'd0, 4'(dv), 5'd0, de, ar, 1'b1}, 4'hF, werr);
      t_en = cyc;
      repeat ($urandom_range(0, 20)) @(posedge clk);
      apb_rd(12'(c * 16 + 4), d, e, t);
      ticks   = (t - t_en) / per;
      exp_cnt = ar ? ticks % (cmp + 1) : ticks;
      checks++;
      if (d !== exp_cnt) begin
        errors++;
        $display("FAIL rand_cnt it%0d ch%0d cmp=%0d per=%0d ar=%b got %0d want %0d",
                 it, c, cmp, per, ar, d, exp_cnt);
      end
      apb_rd(12'(c * 16 + 12), d, e, t);
      ticks = (t - t_en) / per;
      checks++;
      if (d !== {30'd0, ie, ticks >= cmp}) begin
        errors++;
        $display("FAIL rand_int it%0d ch%0d got %h want %h", it, c, d, {30'd0, ie, ticks >= cmp});
      end
      apb_wr(12'(c * 16), 32'd0, 4'hF, werr);
      apb_wr(12'(c * 16 + 12), 32'd1, 4'hF, werr);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic e;
    int unsigned t;
    apb_wr(12'h01C, 32'd2, 4'hF, werr);
    apb_wr(12'h018, 32'd1, 4'hF, werr);
    apb_wr(12'h010, 32'd1, 4'hF, werr);
    repeat (4) @(posedge clk);
    #1;
    bus.tim_psel = 1'b1; bus.tim_penable = 1'b1; bus.tim_pwrite = 1'b0; bus.tim_paddr = 12'h014;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.tim_pready !== 1'b0 || bus.tim_prdata !== 32'd0 || tim_int !== 1'b0) begin
      errors++;
      $display("FAIL midreset_out got rdy=%b rd=%h int=%b want 0", bus.tim_pready, bus.tim_prdata, tim_int);
    end
    bus.tim_psel = 1'b0; bus.tim_penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    apb_rd(12'h014, d, e, t);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL midreset_cnt got %0d want 0", d);
    end
    apb_rd(12'h018, d, e, t);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL midreset_cmp got %h want FFFFFFFF", d);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_reload();
    test_prescaler();
    test_strobe();
    test_halt();
    test_unmapped();
    test_oneshot();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
